// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides and an iterative shift-add MUL.
// One operation in flight; result and flags hold until the sink takes them.
module alu_seq #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v,
   output logic             err
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready depends on state only; out_valid/result/flags are registers held until taken.

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SHL = 4'd2;
   localparam logic [3:0] OP_SHR = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [3:0]           op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [WIDTH:0]       ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic                 alu_err;

   logic                 accept;
   logic                 mul_done;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && (state_q == IDLE);
   assign mul_done = (op_q == OP_MUL) && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Single-cycle ops spend one BUSY cycle computing from the captured operands.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if ((op_q != OP_MUL) || mul_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ext     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op_q)
         OP_ADD: begin
            ext     = {1'b0, a_q} + {1'b0, b_q};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            ext     = {1'b0, a_q} - {1'b0, b_q};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SHL:  alu_res = (b_q >= SHIFT_LIM) ? '0 : (a_q << b_q);
         OP_SHR:  alu_res = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q);
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_NOT:  alu_res = ~a_q;
         OP_MUL:  alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_n    <= 1'b0;
         flag_v    <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q     <= op;
                  a_q      <= a;
                  b_q      <= b;
                  acc_q    <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, a};
                  mplier_q <= b;
                  cnt_q    <= CNT_W'(WIDTH);
               end
            end
            BUSY: begin
               if (op_q == OP_MUL) begin
                  if (cnt_q != '0) begin
                     if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                     mcand_q  <= mcand_q << 1;
                     mplier_q <= mplier_q >> 1;
                     cnt_q    <= cnt_q - CNT_W'(1);
                  end else begin
                     out_valid <= 1'b1;
                     result    <= acc_q[WIDTH-1:0];
                     flag_z    <= (acc_q[WIDTH-1:0] == '0);
                     flag_n    <= acc_q[WIDTH-1];
                     flag_c    <= |acc_q[2*WIDTH-1:WIDTH];
                     flag_v    <= 1'b0;
                     err       <= 1'b0;
                  end
               end else begin
                  out_valid <= 1'b1;
                  result    <= alu_res;
                  flag_z    <= (alu_res == '0);
                  flag_n    <= alu_res[WIDTH-1];
                  flag_c    <= alu_c;
                  flag_v    <= alu_v;
                  err       <= alu_err;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with fixed expectations plus randomized ops
// checked against an arithmetic reference model through a scoreboard queue.
`timescale 1ns/1ps
module tb_alu_seq;

   localparam int W  = 8;
   localparam int BW = W + 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         flag_z, flag_c, flag_n, flag_v, err;

   logic [BW-1:0] dut_b;
   logic [BW-1:0] exp_q[$];
   time           acc_t_q[$];
   int            lat_q[$];

   int tests = 0;
   int fails = 0;
   bit rand_ready = 1'b0;
   bit ov_prev = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
      .flag_v(flag_v), .err(err)
   );

   assign dut_b = {err, flag_v, flag_n, flag_c, flag_z, result};

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic logic [BW-1:0] mk(logic [W-1:0] r, bit c, bit v, bit n, bit z, bit e);
      return {e, v, n, c, z, r};
   endfunction

   // Reference model: plain integer arithmetic, signed overflow via true signed sums.
   function automatic logic [BW-1:0] model(int opc, int av, int bv);
      longint full, r, sa, sb, s;
      bit c, v, e;
      c = 0; v = 0; e = 0; r = 0; full = 0; s = 0;
      sa = (av >= 2**(W-1)) ? av - 2**W : av;
      sb = (bv >= 2**(W-1)) ? bv - 2**W : bv;
      case (opc)
         0: begin
            full = av + bv; r = full % (2**W); c = (full >= 2**W);
            s = sa + sb; v = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
         end
         1: begin
            full = av - bv; r = (full + 2**W) % (2**W); c = (av < bv);
            s = sa - sb; v = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
         end
         2: r = (bv >= W) ? 0 : (av * (2**bv)) % (2**W);
         3: r = (bv >= W) ? 0 : av / (2**bv);
         4: r = av & bv;
         5: r = av | bv;
         6: r = av ^ bv;
         7: r = (2**W - 1) - av;
         8: begin full = av * bv; r = full % (2**W); c = (full >= 2**W); end
         default: e = 1;
      endcase
      return mk(W'(r), c, v, (r >= 2**(W-1)), (r == 0), e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // driver
   task automatic issue(input logic [3:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [BW-1:0] e);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL issue_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
         return;
      end
      in_valid = 1'b1; op = opc; a = av; b = bv;
      @(posedge clk);
      exp_q.push_back(e);
      acc_t_q.push_back($time);
      lat_q.push_back((opc == 4'd8) ? W + 1 : 1);
      #1;
      in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete(); acc_t_q.delete(); lat_q.delete();
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_out_valid: result=0x%0h with empty scoreboard at %0t", result, $time);
            end else begin
               if (!ov_prev) begin
                  int lat;
                  lat = int'((($time - 5) - acc_t_q[0]) / 10);
                  tests++;
                  if (lat != lat_q[0]) begin
                     fails++;
                     $display("FAIL latency: got %0d cycles, expected %0d", lat, lat_q[0]);
                  end
               end
               tests++;
               if (dut_b !== exp_q[0]) begin
                  fails++;
                  $display("FAIL result_flags: got {err,v,n,c,z,res}=0x%0h, expected 0x%0h at %0t",
                           dut_b, exp_q[0], $time);
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(acc_t_q.pop_front());
                  void'(lat_q.pop_front());
               end
            end
         end
         ov_prev = (out_valid === 1'b1);
      end
   end

   initial begin
      logic [3:0]   opc;
      logic [W-1:0] av, bv;

      #1 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", dut_b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(4'd0, 8'hF0, 8'h20, mk(8'h10, 1, 0, 0, 0, 0));
      issue(4'd0, 8'h7F, 8'h01, mk(8'h80, 0, 1, 1, 0, 0));
      issue(4'd1, 8'h05, 8'h07, mk(8'hFE, 1, 0, 1, 0, 0));
      issue(4'd1, 8'h80, 8'h01, mk(8'h7F, 0, 1, 0, 0, 0));
      issue(4'd2, 8'h81, 8'd1,  mk(8'h02, 0, 0, 0, 0, 0));
      issue(4'd3, 8'h81, 8'd7,  mk(8'h01, 0, 0, 0, 0, 0));
      issue(4'd2, 8'hFF, 8'd9,  mk(8'h00, 0, 0, 0, 1, 0));
      issue(4'd3, 8'hFF, 8'd8,  mk(8'h00, 0, 0, 0, 1, 0));
      issue(4'd7, 8'h3C, 8'h55, mk(8'hC3, 0, 0, 1, 0, 0));

      wait_drain();
      issue(4'd8, 8'h12, 8'h10, mk(8'h20, 1, 0, 0, 0, 0));
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("mul_busy_in_ready", in_ready, 0);
      end
      issue(4'd8, 8'h0F, 8'h0F, mk(8'hE1, 0, 0, 1, 0, 0));

      // backpressure: result must hold and extra requests must be refused
      wait_drain();
      @(negedge clk);
      out_ready = 1'b0;
      issue(4'd4, 8'hCC, 8'hAA, mk(8'h88, 0, 0, 1, 0, 0));
      repeat (5) begin
         @(negedge clk);
         in_valid = 1'b1; op = 4'd0; a = W'($urandom); b = W'($urandom);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      @(negedge clk);
      out_ready = 1'b1;
      issue(4'd12, 8'h5A, 8'hA5, mk(8'h00, 0, 0, 0, 1, 1));

      // reset in the middle of a MUL
      wait_drain();
      issue(4'd8, 8'h5A, 8'h3C, model(8, 8'h5A, 8'h3C));
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midmul_reset_in_ready", in_ready, 1);
      chk("midmul_reset_out_valid", out_valid, 0);
      chk("midmul_reset_outputs", dut_b, 0);
      exp_q.delete(); acc_t_q.delete(); lat_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", in_ready, 1);
      repeat (12) begin
         @(negedge clk);
         chk("no_stale_out_valid", out_valid, 0);
      end
      issue(4'd0, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0, 0));
      wait_drain();

      // randomized ops with random sink backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 80; n++) begin
         opc = 4'($urandom_range(0, 15));
         av  = W'($urandom);
         bv  = ((opc == 4'd2) || (opc == 4'd3)) ? W'($urandom_range(0, 11)) : W'($urandom);
         issue(opc, av, bv, model(int'(opc), int'(av), int'(bv)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();
      @(negedge clk);
      rand_ready = 1'b0;
      out_ready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, registered ALU: the next generation of the team's 4-bit combinational op set (add, sub, shift left/right, and, or, xor, not).
- Generalised to WIDTH bits, with status flags, an error flag, and a new multi-cycle MUL opcode (iterative shift-add).
- Sits between an operand source and a result sink using valid/ready on both sides.
- Processes one operation at a time; the result is held stable until the sink consumes it.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 to 32.
- CNT_W, $clog2(WIDTH+1), width of the MUL iteration counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- op  input  4  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B, or the shift amount.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  sink accepts the result.
- result  output  WIDTH  operation result.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / borrow / MUL high part non-zero.
- flag_n  output  1  result MSB.
- flag_v  output  1  signed overflow (ADD/SUB only).
- err  output  1  illegal opcode.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - State = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - result = 0.
  - All flags = 0; err = 0.
- Opcodes:
  - 0 ADD: a+b; c = carry-out; v = signed overflow.
  - 1 SUB: a-b; c = borrow (a<b unsigned); v = signed overflow.
  - 2 SHL: a<<b, logical.
  - 3 SHR: a>>b, logical.
  - 4 AND, 5 OR, 6 XOR: bitwise a op b.
  - 7 NOT: ~a; b ignored.
  - 8 MUL: unsigned a*b; result = low WIDTH bits; c = 1 if high WIDTH bits are non-zero.
  - 9-15 illegal: result = 0, err = 1, z = 1.
- Shifts: the full b value is the shift amount; b >= WIDTH gives result 0. For opcodes 2-8, c = 0 (except MUL as above) and v = 0.
- z and n are always computed from the final result.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On an accept edge (in_valid && in_ready), a, b and op are captured.
    - Non-MUL opcode: result and flags are computed from the captured values; go to DONE. out_valid is high the cycle after the accept edge (latency 1).
    - MUL: accumulator cleared, counter = WIDTH; go to BUSY.
  - BUSY: in_ready = 0. Each cycle, if multiplier LSB = 1, add the shifted multiplicand into a 2*WIDTH accumulator; shift the multiplier right and the multiplicand left; counter decrements. When the counter reaches 0, load result and flags and go to DONE. MUL out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid = 1, in_ready = 0. result and flags are held stable while out_ready = 0. On out_valid && out_ready, go to IDLE and clear out_valid. The next accept is possible at the following edge; no same-cycle turnaround.
- Inputs a, b and op are ignored except at the accept edge. Changing them while BUSY or DONE has no effect.
- out_ready is ignored outside DONE.
- An rst_n assertion in any state, including mid-MUL, immediately forces reset values. Any partial accumulation is discarded, and no out_valid is produced for the aborted operation.
- After release of rst_n, the first accept can occur at the first rising clk edge.
- All outputs are registered; no combinational path from inputs to outputs except none (in_ready is decoded from state only).

Test Plan:
- ADD: a=0xF0, b=0x20 -> result=0x10, c=1, z=0, n=0, v=0, out_valid one cycle after accept. Then a=0x7F, b=0x01 -> 0x80, v=1, n=1, c=0.
- SUB: a=0x05, b=0x07 -> 0xFE, c=1, n=1, v=0. Then a=0x80, b=0x01 -> 0x7F, v=1, c=0.
- Shifts: SHL a=0x81, b=1 -> 0x02. SHR a=0x81, b=7 -> 0x01. SHL a=0xFF, b=9 -> 0x00, z=1.
- MUL: a=0x12, b=0x10 -> result=0x20, c=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout. Then a=0x0F, b=0x0F -> 0xE1, c=0.
- Backpressure and illegal opcode: hold out_ready=0 for 5 cycles after an AND of 0xCC and 0xAA -> result=0x88 stable, in_valid pulses not accepted. op=12 -> err=1, result=0, z=1.
- Reset mid-MUL: assert rst_n low 4 cycles into a MUL -> all outputs at reset values asynchronously, in_ready=1 after release, no stale out_valid; then ADD 1+1 -> 0x02.
